// File: rtl/pwm_shadow_gen.sv
// PWM generator with shadowed period/high-time registers reloaded only at period wraps.
// Optional macro PWM_RAMP_EN limits the high-time change per period to RAMP_STEP.
module pwm_shadow_gen #(
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 2,
  parameter int RAMP_STEP  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] htime,
  output logic             led,
  output logic             cyc_end,
  output logic             busy,
  output logic             state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_htime;

  logic [CNT_W-1:0] cnt_nxt;
  logic             at_wrap;
  logic [CNT_W-1:0] ld_period;
  logic [CNT_W-1:0] ld_target;
  logic [CNT_W-1:0] ld_htime;

  assign state_dbg = state;

  always_comb begin
    cnt_nxt   = cnt + ONE;
    at_wrap   = (cnt == act_period - ONE);
    ld_period = (period < MINP) ? MINP : period;
    ld_target = (htime > ld_period) ? ld_period : htime;
    ld_htime  = ld_target;
`ifdef PWM_RAMP_EN
    // Move toward the target by at most one step, then re-clamp to the new period.
    if (ld_target > act_htime) begin
      if (ld_target - act_htime > CNT_W'(RAMP_STEP)) ld_htime = act_htime + CNT_W'(RAMP_STEP);
    end else begin
      if (act_htime - ld_target > CNT_W'(RAMP_STEP)) ld_htime = act_htime - CNT_W'(RAMP_STEP);
    end
    if (ld_htime > ld_period) ld_htime = ld_period;
`endif
  end

`ifndef PWM_RAMP_EN
  logic unused_ramp;
  assign unused_ramp = (RAMP_STEP != 0);
`endif

  // Outputs are computed from next-cycle cnt and shadow values so they align with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      act_period <= '0;
      act_htime  <= '0;
      led        <= 1'b0;
      cyc_end    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          led     <= 1'b0;
          cyc_end <= 1'b0;
          busy    <= 1'b0;
          if (en) begin
            state      <= RUN;
            act_period <= ld_period;
            act_htime  <= ld_target;
            led        <= (ld_target != '0);
            cyc_end    <= (ld_period == ONE);
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (at_wrap) begin
            cnt <= '0;
            if (en) begin
              act_period <= ld_period;
              act_htime  <= ld_htime;
              led        <= (ld_htime != '0);
              cyc_end    <= (ld_period == ONE);
              busy       <= 1'b1;
            end else begin
              state   <= IDLE;
              led     <= 1'b0;
              cyc_end <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            cnt     <= cnt_nxt;
            led     <= (cnt_nxt < act_htime);
            cyc_end <= (cnt_nxt == act_period - ONE);
            busy    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_shadow_gen.sv
// Directed bench for pwm_shadow_gen: vector table plus hand-written reset, clamp and ramp sequences.
module tb_pwm_shadow_gen;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [W-1:0] period = '0;
  logic [W-1:0] htime  = '0;
  logic         led, cyc_end, busy, state_dbg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         en;
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic         led;
    logic         ce;
    logic         busy;
  } vec_t;

  vec_t tv[$];

  pwm_shadow_gen #(.CNT_W(W), .MIN_PERIOD(2), .RAMP_STEP(2)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .htime(htime),
    .led(led), .cyc_end(cyc_end), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Running cycle at count c with active high time ah and active period ap.
  function automatic void add_run(input logic e, input int p, input int h,
                                  input int c, input int ah, input int ap);
    vec_t v;
    v.en = e; v.p = W'(p); v.h = W'(h);
    v.led = (c < ah); v.ce = (c == ap - 1); v.busy = 1'b1;
    tv.push_back(v);
  endfunction

  function automatic void add_idle(input logic e, input int p, input int h);
    vec_t v;
    v.en = e; v.p = W'(p); v.h = W'(h);
    v.led = 1'b0; v.ce = 1'b0; v.busy = 1'b0;
    tv.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  int hi_cnt;
  int exp_hi[6];

  initial begin
    // Basic 10/3 run, stop request at cnt=2, then idle.
    for (int i = 0; i < 22; i++) add_run(1'b1, 10, 3, i % 10, 3, 10);
    for (int i = 22; i < 30; i++) add_run(1'b0, 10, 3, i % 10, 3, 10);
    add_idle(1'b0, 10, 3);
    add_idle(1'b0, 10, 3);
    // Restart; drop en at cnt=2 and raise it at cnt=5 -> no gap.
    add_run(1'b1, 10, 3, 0, 3, 10);
    add_run(1'b1, 10, 3, 1, 3, 10);
    for (int c = 2; c < 5; c++) add_run(1'b0, 10, 3, c, 3, 10);
    for (int c = 5; c < 10; c++) add_run(1'b1, 10, 3, c, 3, 10);
    // htime 3 -> 8 at cnt=4: current period keeps 3, next period shows 8.
    for (int c = 0; c < 4; c++) add_run(1'b1, 10, 3, c, 3, 10);
    for (int c = 4; c < 10; c++) add_run(1'b1, 10, 8, c, 3, 10);
    for (int c = 0; c < 10; c++) add_run(1'b1, 10, 8, c, 8, 10);
    // htime equal to and above the period: led stays high.
    for (int i = 0; i < 8; i++) add_run(1'b1, 4, 4, i % 4, 4, 4);
    for (int i = 0; i < 8; i++) add_run(1'b1, 4, 9, i % 4, 4, 4);

    step();
    chk1("rst.led", led, 1'b0);
    chk1("rst.cyc_end", cyc_end, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    rst = 1'b0;

    foreach (tv[k]) begin
      en = tv[k].en; period = tv[k].p; htime = tv[k].h;
      step();
      chk1($sformatf("vec%0d.led", k), led, tv[k].led);
      chk1($sformatf("vec%0d.cyc_end", k), cyc_end, tv[k].ce);
      chk1($sformatf("vec%0d.busy", k), busy, tv[k].busy);
    end

    // period=1 clamps to 2; htime=5 clamps to 2 -> led continuously high.
    do_reset();
    en = 1'b1; period = W'(1); htime = W'(5);
    for (int i = 0; i < 6; i++) begin
      step();
      chk1($sformatf("clamp%0d.led", i), led, 1'b1);
      chk1($sformatf("clamp%0d.cyc_end", i), cyc_end, (i % 2) == 1);
    end
    htime = '0;
    for (int i = 6; i < 10; i++) begin
      step();
      chk1($sformatf("zero%0d.led", i), led, 1'b0);
      chk1($sformatf("zero%0d.cyc_end", i), cyc_end, (i % 2) == 1);
      chk1($sformatf("zero%0d.busy", i), busy, 1'b1);
    end

    // Asynchronous reset mid-period at cnt=1.
    do_reset();
    en = 1'b1; period = W'(10); htime = W'(3);
    step(); step();
    chk1("pre_rst.led", led, 1'b1);
    rst = 1'b1;
    #1;
    chk1("async_rst.led", led, 1'b0);
    chk1("async_rst.busy", busy, 1'b0);
    chk1("async_rst.cyc_end", cyc_end, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1($sformatf("rst_hold%0d.cyc_end", i), cyc_end, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("post_rst%0d.busy", i), busy, 1'b0);
    end
    en = 1'b1;
    step();
    chk1("first_load.busy", busy, 1'b1);
    chk1("first_load.led", led, 1'b1);

    // High time per period for htime 2 -> 9 at period 20.
`ifdef PWM_RAMP_EN
    exp_hi = '{2, 4, 6, 8, 9, 9};
`else
    exp_hi = '{2, 9, 9, 9, 9, 9};
`endif
    do_reset();
    en = 1'b1; period = W'(20); htime = W'(2);
    for (int per = 0; per < 6; per++) begin
      hi_cnt = 0;
      for (int s = 0; s < 20; s++) begin
        if (per == 0 && s == 1) htime = W'(9);
        step();
        if (led) hi_cnt++;
      end
      chk_int($sformatf("ramp_period%0d.high", per), hi_cnt, exp_hi[per]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_shadow_gen.md
PWM_SHADOW_GEN -- requirements
Module: pwm_shadow_gen

Interface
REQ-001 Parameter CNT_W, default 24, SHALL set the width of the period, htime and internal counter.
REQ-002 Parameter MIN_PERIOD, default 2, SHALL be the smallest period in clk cycles the block accepts.
REQ-003 Parameter RAMP_STEP, default 1000, SHALL be the maximum high-time change per period when PWM_RAMP_EN is defined.
REQ-004 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  run request; 1 = generate PWM, 0 = stop at the next period boundary.
REQ-007 period  input  CNT_W  requested period in clk cycles (unsigned); sampled only at load points.
REQ-008 htime  input  CNT_W  requested high time in clk cycles (unsigned); sampled only at load points.
REQ-009 led  output  1  registered PWM output; 1 = lit.
REQ-010 cyc_end  output  1  registered one-clk pulse on the last cycle of every completed period.
REQ-011 busy  output  1  registered; 1 while in state RUN.

Function
REQ-012 The block SHALL have two states: IDLE and RUN.
REQ-013 In IDLE: cnt=0, led=0, cyc_end=0, busy=0.
REQ-014 IDLE->RUN when en=1 is sampled; the same edge SHALL perform a load, and the next cycle SHALL have cnt=0 and busy=1.
REQ-015 Load: act_period = max(period, MIN_PERIOD); act_htime = min(htime, act_period).
REQ-016 In RUN, cnt SHALL increment by 1 each cycle and wrap from act_period-1 to 0.
REQ-017 led SHALL be 1 exactly on the cycles where cnt < act_htime, with no extra register lag.
REQ-018 cyc_end SHALL be 1 exactly on the cycles where cnt = act_period-1.
REQ-019 At every wrap (cnt = act_period-1) with en=1, a load SHALL occur; the new values apply from the following cnt=0.
REQ-020 Changes to period or htime mid-period SHALL NOT affect led before the next wrap; this is glitch-free shadowing.
REQ-021 When en=0 is sampled in RUN, the block SHALL finish the current period and enter IDLE on the wrap edge (cyc_end is still pulsed).
REQ-022 When en returns to 1 before the wrap, the stop request SHALL be cancelled, with no gap in the output.
REQ-023 act_htime = 0 SHALL keep led = 0 for the whole period.
REQ-024 act_htime = act_period SHALL keep led = 1 for the whole period.
REQ-025 All comparisons SHALL be unsigned at CNT_W bits; cnt SHALL never reach act_period.

Reset
REQ-026 Asserting rst at any time, including mid-period, SHALL immediately force IDLE, cnt=0, act_period=0, act_htime=0, led=0, cyc_end=0 and busy=0.
REQ-027 After rst deasserts, the first load SHALL occur only on an en=1 sample.

Configuration
REQ-028 With PWM_RAMP_EN defined, each load after the first load following IDLE SHALL move act_htime toward the clamped target by at most RAMP_STEP.
REQ-029 The first load following IDLE SHALL take the clamped target directly, and the ramped value SHALL still be clamped to act_period.
REQ-030 With PWM_RAMP_EN undefined, act_htime SHALL jump to the clamped target at every load, and RAMP_STEP is unused.

Verification
REQ-031 rst, then en=1, period=10, htime=3 -> led is high for 3 cycles and low for 7 cycles, repeating; cyc_end is high at cnt=9.
REQ-032 Running with period=10, htime=3; at cnt=4 change htime to 8 -> the current period still shows 3 high cycles, and the next period shows 8.
REQ-033 period=1, htime=5 -> the block clamps to period 2 and keeps led high continuously; htime=0 -> led stays low.
REQ-034 Running with period=10; drop en at cnt=2 -> the block completes the period, cyc_end pulses, then busy=0 and led=0; a second test raises en again at cnt=5 -> the output continues uninterrupted.
REQ-035 Assert rst at cnt=1 of a period with htime=3 -> led=0 and busy=0 in the same cycle, and no cyc_end pulse occurs.
REQ-036 PWM_RAMP_EN, RAMP_STEP=2, period=20, htime 2->9 -> successive periods have high times of 2, 4, 6, 8, 9, 9.
